// File: rtl/oam_dma_master_if.sv
// ---------------------------------------------------------------------------
// oam_dma_master_if
// Arbitrated CPU-side memory bus, as seen by a bus initiator.
//   I_BUS_GNT  arbiter -> initiator  1 = initiator owns the bus
//   O_BUS_REQ  initiator -> arbiter  bus request
//   O_ADDR     initiator -> memory   16-bit bus address
//   O_WE_L     initiator -> memory   active-low write strobe
//   O_RE_L     initiator -> memory   active-low read strobe
// The bidirectional data byte stays a plain inout port on the initiator so
// that its tri-state driver lives next to the logic that enables it.
// ---------------------------------------------------------------------------
interface oam_dma_master_if;
    logic        I_BUS_GNT;
    logic        O_BUS_REQ;
    logic [15:0] O_ADDR;
    logic        O_WE_L;
    logic        O_RE_L;

    modport master (input I_BUS_GNT, output O_BUS_REQ, O_ADDR, O_WE_L, O_RE_L);
    modport slave  (output I_BUS_GNT, input O_BUS_REQ, O_ADDR, O_WE_L, O_RE_L);
endinterface

// File: rtl/oam_dma_master.sv
// ---------------------------------------------------------------------------
// oam_dma_master
// GBC OAM DMA bus initiator. On an accepted start pulse it copies P_LEN bytes
// from {I_SRC_HI,8'h00} to P_DST_BASE, one bus read then one bus write per
// byte, holding the bus only while the arbiter grants it.
// Ports:
//   I_CLK, I_RESET_L  clock, asynchronous active-low reset
//   I_START           1-cycle start request, honoured only when idle
//   I_SRC_HI          source page, latched when the start is accepted
//   bus               arbitrated bus (grant/request/address/strobes)
//   IO_DATA           bus data; driven only while the write strobe is low
//   O_BUSY            transfer in progress (request through done)
//   O_DONE            1-cycle pulse after the last byte is written
// All outputs come straight from flops so the strobes cannot glitch.
// ---------------------------------------------------------------------------
module oam_dma_master #(
    parameter int          P_LEN       = 160,      // 1..256
    parameter logic [15:0] P_DST_BASE  = 16'hFE00,
    parameter int          P_READ_WAIT = 2         // >= 1
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET_L,
    input  logic                    I_START,
    input  logic [7:0]              I_SRC_HI,
    oam_dma_master_if.master        bus,
    inout  wire  [7:0]              IO_DATA,
    output logic                    O_BUSY,
    output logic                    O_DONE
);
    localparam int WW = (P_READ_WAIT > 1) ? $clog2(P_READ_WAIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_t;

    state_t        r_state;
    logic [8:0]    r_count;     // 9 bits so that P_LEN=256 still reaches its last byte
    logic [7:0]    r_src;
    logic [7:0]    r_data;
    logic [WW-1:0] r_wait;
    logic [15:0]   r_addr;
    logic          r_we_l;
    logic          r_re_l;
    logic          r_req;
    logic          r_busy;
    logic          r_done;

    logic [8:0]    w_next_cnt;
    logic [15:0]   w_rd_addr;
    logic [15:0]   w_next_rd_addr;
    logic [15:0]   w_wr_addr;
    logic          w_last;
    logic          w_rd_last;

    assign w_next_cnt     = r_count + 9'd1;
    // source addresses wrap modulo 64K (page FF runs up to 16'hFFFF)
    assign w_rd_addr      = {r_src, 8'h00} + {8'h00, r_count[7:0]};
    assign w_next_rd_addr = {r_src, 8'h00} + {8'h00, w_next_cnt[7:0]};
    assign w_wr_addr      = P_DST_BASE + {8'h00, r_count[7:0]};
    assign w_last         = (r_count == 9'(P_LEN - 1));
    assign w_rd_last      = (r_wait == WW'(P_READ_WAIT - 1));

    assign bus.O_BUS_REQ  = r_req;
    assign bus.O_ADDR     = r_addr;
    assign bus.O_WE_L     = r_we_l;
    assign bus.O_RE_L     = r_re_l;
    assign O_BUSY         = r_busy;
    assign O_DONE         = r_done;
    // tie the data driver to the write strobe flop: released the cycle after WRITE
    assign IO_DATA        = r_we_l ? 8'hzz : r_data;

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_src   <= '0;
            r_data  <= '0;
            r_wait  <= '0;
            r_addr  <= '0;
            r_we_l  <= 1'b1;
            r_re_l  <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (I_START) begin
                        r_src   <= I_SRC_HI;
                        r_count <= '0;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.I_BUS_GNT) begin
                        r_addr  <= w_rd_addr;
                        r_re_l  <= 1'b0;
                        r_wait  <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // grant is not looked at here: a started byte always completes
                    if (w_rd_last) begin
                        r_data  <= IO_DATA;
                        r_re_l  <= 1'b1;
                        r_we_l  <= 1'b0;
                        r_addr  <= w_wr_addr;
                        r_state <= S_WRITE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_we_l <= 1'b1;
                    if (w_last) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= w_next_cnt;
                        if (bus.I_BUS_GNT) begin
                            // back-to-back byte, no REQ bubble
                            r_addr  <= w_next_rd_addr;
                            r_re_l  <= 1'b0;
                            r_wait  <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oam_dma_master.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_master
// Three DUTs (P_LEN = 160, 1, 256) on their own buses. Each bus has a memory
// model that returns memval(addr) while the read strobe is low and holds a
// keeper pattern (8'h3C) while both strobes are high, so any DUT drive outside
// a write shows up as a corrupted bus byte. Expected per-cycle behaviour comes
// from an event-time model: bytes cost 3 cycles, grant is only consulted in
// REQ and at the end of each write.
// ---------------------------------------------------------------------------
module tb_oam_dma_master;
    localparam int MAXC = 1200;
    localparam int RW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start [3];
    logic [7:0]  srchi [3];
    logic        gnt   [3];
    logic        re_l  [3];
    logic        we_l  [3];
    logic        req   [3];
    logic        busy  [3];
    logic        done_o[3];
    logic [15:0] addr  [3];
    logic [7:0]  io    [3];

    int total = 0;
    int bad   = 0;

    // page C1 gives byte i = i ^ 8'h5A
    function automatic logic [7:0] memval(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9B;
    endfunction

    function automatic int len_of(int i);
        return (i == 0) ? 160 : (i == 1) ? 1 : 256;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int LEN = (g == 0) ? 160 : (g == 1) ? 1 : 256;
        oam_dma_master_if bif();
        wire [7:0] w_io;
        wire       tb_en;
        wire [7:0] tb_val;

        assign bif.I_BUS_GNT = gnt[g];
        assign tb_en  = bif.O_WE_L || !bif.O_RE_L;
        assign tb_val = !bif.O_RE_L ? memval(bif.O_ADDR) : 8'h3C;
        assign w_io   = tb_en ? tb_val : 8'hzz;

        oam_dma_master #(.P_LEN(LEN)) dut (
            .I_CLK     (clk),
            .I_RESET_L (rst_n),
            .I_START   (start[g]),
            .I_SRC_HI  (srchi[g]),
            .bus       (bif.master),
            .IO_DATA   (w_io),
            .O_BUSY    (busy[g]),
            .O_DONE    (done_o[g])
        );

        assign re_l[g] = bif.O_RE_L;
        assign we_l[g] = bif.O_WE_L;
        assign req[g]  = bif.O_BUS_REQ;
        assign addr[g] = bif.O_ADDR;
        assign io[g]   = w_io;

        always @(negedge clk) begin
            chk("strobe_excl", {31'd0, !(!re_l[g] && !we_l[g])}, 32'd1);
            if (we_l[g])
                chk("bus_hold", {24'd0, io[g]}, {24'd0, re_l[g] ? 8'h3C : memval(addr[g])});
        end
    end

    task automatic chk_reset(string name, int i);
        chk(name, {11'd0, addr[i], re_l[i], we_l[i], busy[i], req[i], done_o[i]},
                  {11'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk({name, "_io"}, {24'd0, io[i]}, {24'd0, 8'h3C});
    endtask

    // gmode: 0 grant tied high, 1 grant low for cycles 19..28, 2 random grant
    task automatic run_xfer(string tag, int inst, logic [7:0] src, int gmode, int spur, int exp_done);
        bit          g    [MAXC];
        bit          e_re [MAXC];
        bit          e_we [MAXC];
        logic [15:0] e_addr[MAXC];
        logic [7:0]  e_wd [MAXC];
        int len, r, u, wc, done_c, ndone, first_done;
        bit ok;
        len = len_of(inst);
        for (int n = 0; n < MAXC; n++) begin
            case (gmode)
                0:       g[n] = 1'b1;
                1:       g[n] = !(n >= 19 && n <= 28);
                default: g[n] = ($urandom_range(0, 3) != 0);
            endcase
            e_re[n] = 0; e_we[n] = 0; e_addr[n] = '0; e_wd[n] = '0;
        end
        // cycle 0 = start cycle, REQ from cycle 1
        done_c = 0; ok = 1;
        u = 1;
        while (u < MAXC - 8 && !g[u]) u++;
        r = u + 1;
        for (int j = 0; j < len; j++) begin
            if (r + RW >= MAXC - 4) begin ok = 0; break; end
            for (int k = 0; k < RW; k++) begin
                e_re[r+k]   = 1;
                e_addr[r+k] = {src, 8'h00} + 16'(j);
            end
            wc = r + RW;
            e_we[wc]   = 1;
            e_addr[wc] = 16'hFE00 + 16'(j);
            e_wd[wc]   = memval({src, 8'h00} + 16'(j));
            if (j == len - 1) done_c = wc + 1;
            else if (g[wc]) r = wc + 1;
            else begin
                u = wc + 1;
                while (u < MAXC - 8 && !g[u]) u++;
                r = u + 1;
            end
        end
        chk({tag, "_model_range"}, {31'd0, ok}, 32'd1);
        if (!ok) return;

        ndone = 0; first_done = -1;
        for (int n = 0; n <= done_c + 3; n++) begin
            @(negedge clk);
            chk({tag, "_ctl"},
                {27'd0, re_l[inst], we_l[inst], busy[inst], req[inst], done_o[inst]},
                {27'd0, !e_re[n], !e_we[n], (n >= 1 && n <= done_c), (n >= 1 && n < done_c), (n == done_c)});
            if (e_re[n] || e_we[n]) chk({tag, "_addr"}, {16'd0, addr[inst]}, {16'd0, e_addr[n]});
            if (e_we[n])            chk({tag, "_wdata"}, {24'd0, io[inst]}, {24'd0, e_wd[n]});
            if (done_o[inst]) begin
                ndone++;
                if (first_done < 0) first_done = n;
            end
            start[inst] = (n == 0) || (n == spur);
            srchi[inst] = (n == 0) ? src : 8'h80;
            gnt[inst]   = g[n];
        end
        start[inst] = 1'b0;
        gnt[inst]   = 1'b0;
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_done_cycle"}, 32'(first_done), 32'(done_c));
        if (exp_done >= 0) chk({tag, "_done_latency"}, 32'(first_done), 32'(exp_done));
    endtask

    typedef struct {
        int         inst;
        logic [7:0] src;
        int         gmode;
        int         spur;
        int         exp_done;
    } vec_t;

    vec_t tbl [6];
    bit   seen;

    initial begin
        tbl[0] = '{0, 8'hC1, 0,  -1, 482};   // full copy, continuous grant
        tbl[1] = '{0, 8'hC1, 1,  -1, 492};   // grant dropped 10 cycles after byte 5
        tbl[2] = '{0, 8'hC1, 0, 122, 482};   // restart with page 80 at byte 40
        tbl[3] = '{0, 8'hC1, 0, 482, 482};   // start pulse on the DONE cycle
        tbl[4] = '{1, 8'hC1, 0,  -1,   5};   // single-byte transfer
        tbl[5] = '{2, 8'hFF, 0,  -1, 770};   // 256 bytes, source wraps to FFFF

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; srchi[i] = 8'h00; gnt[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset("reset_init", i);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run_xfer($sformatf("tbl%0d", t), tbl[t].inst, tbl[t].src, tbl[t].gmode, tbl[t].spur, tbl[t].exp_done);

        // reset asserted in the middle of a read
        @(negedge clk);
        start[0] = 1'b1; srchi[0] = 8'hC1; gnt[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (!re_l[0]) seen = 1;
        end
        chk("rst_reach_read", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_read", 0);
        @(negedge clk);
        chk_reset("reset_held", 0);
        gnt[0] = 1'b0;
        rst_n  = 1'b1;

        for (int t = 0; t < 6; t++) begin
            if (t % 3 == 2)
                run_xfer($sformatf("rnd%0d", t), 1, 8'($urandom), 2, -1, -1);
            else
                run_xfer($sformatf("rnd%0d", t), 0, 8'($urandom), 2, $urandom_range(1, 300), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
